// File: rtl/dcache_line_wb.sv
// Writeback reader: pulls one cache line byte-wise from the dcache data RAM,
// packs bytes little-endian into 32-bit words and streams them over valid/ready.
module dcache_line_wb #(
   parameter int LINE_AW = 5,
   parameter int MEM_AW  = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [MEM_AW-1:0] line_base,
   output logic              busy,
   output logic              done,
   output logic [LINE_AW-1:0] ram_raddr,
   input  logic [7:0]        ram_dataout,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_valid,
   input  logic              mem_ready
);

   localparam int WW = LINE_AW - 2;

   typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_e;

   state_e                      state_q;
   logic [MEM_AW-LINE_AW-1:0]   base_q;
   logic [WW-1:0]               w_q;
   logic [2:0]                  c_q;
   logic [31:0]                 buf_q;
   logic [LINE_AW-1:0]          raddr_q;
   logic [MEM_AW-1:0]           addr_q;
   logic                        valid_q;
   logic                        done_q;

   logic [WW-1:0]               w_d;
   logic [1:0]                  lane;
   logic                        last_word;
   logic                        unused_base_lsbs;

   assign w_d       = w_q + 1'b1;
   assign last_word = (w_q == {WW{1'b1}});
   // c=1..3 land in lanes 0..2; c=4 wraps c[1:0] to 0, so minus one gives lane 3
   assign lane      = c_q[1:0] - 2'd1;
   assign unused_base_lsbs = ^line_base[LINE_AW-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         w_q     <= '0;
         c_q     <= '0;
         buf_q   <= '0;
         raddr_q <= '0;
         addr_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               raddr_q <= '0;
               if (start) begin
                  base_q  <= line_base[MEM_AW-1:LINE_AW];
                  w_q     <= '0;
                  c_q     <= '0;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               if (c_q != 3'd0) buf_q[{lane, 3'b000} +: 8] <= ram_dataout;
               c_q <= c_q + 3'd1;
               // address for the next cycle's byte; held once all four issued
               if (c_q < 3'd3) raddr_q <= {w_q, c_q[1:0] + 2'd1};
               if (c_q == 3'd4) begin
                  state_q <= WRITE;
                  valid_q <= 1'b1;
                  addr_q  <= {base_q, w_q, 2'b00};
               end
            end
            WRITE: begin
               if (mem_ready) begin
                  valid_q <= 1'b0;
                  w_q     <= w_d;
                  if (last_word) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                     raddr_q <= '0;
                  end else begin
                     c_q     <= '0;
                     raddr_q <= {w_d, 2'b00};
                     state_q <= FETCH;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign ram_raddr = raddr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = buf_q;
   assign mem_valid = valid_q;

endmodule

// File: doc/dcache_line_wb.md
Name: dcache_line_wb

Overview:
- Writeback reader for the dcache byte-wide data RAM (32x8 dual-port, registered read, 1-cycle read latency).
- On a start pulse it reads one cache line byte by byte through the RAM read port.
- It packs the bytes little-endian into 32-bit words and streams the words to the memory side over a valid/ready handshake.
- It sits between the dcache eviction logic and the memory write path.

Parameters:
- LINE_AW, 5, line byte-address width; line = 2^LINE_AW bytes, words per line = 2^(LINE_AW-2); legal values are 3 or greater.
- MEM_AW, 32, memory byte-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request writeback of one line; sampled only in IDLE.
- line_base  in  MEM_AW  byte address of the line; low LINE_AW bits are ignored (forced 0).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the last word handshake.
- ram_raddr  out  LINE_AW  RAM read address.
- ram_dataout  in  8  RAM read data, valid one cycle after ram_raddr.
- mem_addr  out  MEM_AW  word byte address; low 2 bits are always 0.
- mem_wdata  out  32  packed word; byte k of the word is at bits [8k+7:8k].
- mem_valid  out  1  word offered.
- mem_ready  in  1  memory accepts the word.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; busy, done, mem_valid, ram_raddr, mem_addr, mem_wdata and all counters clear to 0. A reset mid-line aborts the line; no done pulse is produced and no partial word is left pending.
- Registers:
  - base latch: line_base with the low LINE_AW bits zeroed.
  - word counter w: LINE_AW-2 bits.
  - byte counter c: 0..4.
  - 32-bit packing buffer.
- IDLE:
  - ram_raddr = 0, mem_valid = 0.
  - If start=1: latch the base, set w=0 and c=0, go to FETCH.
- FETCH (5 cycles per word):
  - ram_raddr = {w, c[1:0]} while c<4; it holds its last value when c=4.
  - At each edge with c≥1, capture ram_dataout into byte lane c-1 of the buffer.
  - c increments each cycle; at the edge where c=4, go to WRITE.
- WRITE:
  - mem_valid = 1, mem_addr = base + 4*w, mem_wdata = buffer.
  - mem_addr and mem_wdata are registered and stay stable while mem_valid=1 and mem_ready=0.
  - mem_valid never drops without a handshake.
  - On an edge with mem_valid & mem_ready:
    - If w is the last word: go to IDLE and pulse done=1 for the following cycle only.
    - Otherwise: w+1, c=0, go to FETCH; mem_valid=0 in the next cycle.
- Timing:
  - Throughput with mem_ready tied high is 6 cycles per word.
  - Default line (8 words): the first mem_valid is in cycle 5 after the start edge; done is high in cycle 48.
  - Each cycle of mem_ready=0 during WRITE adds exactly one cycle.
- Start handling:
  - start during busy is ignored and not queued.
  - start in the cycle done is high (state IDLE) is accepted; the new line's FETCH begins the next cycle.
- Counter wrap: w wraps naturally at the last word; the last-word test uses w == all-ones.
- Address arithmetic:
  - mem_addr = {base[MEM_AW-1:LINE_AW], w, 2'b00}; no carry out of the line.
  - base near the top of the address space does not wrap into other lines.
- RAM port rules:
  - This block only drives the RAM read port.
  - The RAM write port must not target the line being written back while busy.
  - If it does, the bytes read are whatever the RAM returns (old data when read and write hit the same address in the same cycle). This block has no guard for it.
- mem_ready is ignored while mem_valid=0.

Test Plan:
1. RAM byte i = 0x10+i (i=0..31), line_base=0x0000_1240, mem_ready=1, one start pulse.
   - 8 words; first word addr 0x1240, data 0x13121110; last word addr 0x125C, data 0x2F2E2D2C.
   - ram_raddr sequence 0,1,2,3 per word.
   - done high in exactly cycle 48; busy high in cycles 0-47.
2. Same as 1, but mem_ready=0 for 3 cycles when word 2 (addr 0x1248) is first offered.
   - mem_valid, mem_addr and mem_wdata=0x1B1A1918 are held stable.
   - Word 3 appears 3 cycles later than in test 1; done is in cycle 51.
3. line_base=0x0000_1245, plus a second start pulse while busy.
   - Addresses are 0x1240..0x125C.
   - Exactly one done pulse and 8 handshakes.
4. Assert reset_n low for 1 cycle during FETCH of word 5.
   - All outputs are 0 immediately (asynchronously); no done pulse.
   - A later start completes a full 8-word line correctly.
5. Hold start high continuously with mem_ready=1.
   - Lines run back-to-back; done is in cycles 48 and 97; the second line begins with ram_raddr=0 in cycle 49.
